axi_fifo_sync_flags: RTL and testbench

Single-clock AXI4-Stream FIFO: 2^SIZE entries, first-word-fall-through, with registered occupancy, full and empty status outputs. Carries tdata plus tlast per beat. Used as a rate-decoupling buffer between a stream producer and consumer in the same clock domain. Exposes status flags for flow-control and monitoring logic.

---
 rtl/axi_fifo_pkg.sv | 15 +
 rtl/axi_fifo_sync_flags_if.sv | 14 +
 rtl/axi_fifo_ram.sv | 27 ++
 rtl/axi_fifo_sync_flags.sv | 78 +++++++
 tb/tb_axi_fifo_sync_flags.sv | 136 +++++++++++++
 5 files changed

// File: rtl/axi_fifo_pkg.sv
// axi_fifo_pkg: shared depth derivation and occupancy compare helpers for the stream FIFO
package axi_fifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 5;

    function automatic int depth_of(input int size);
        return 1 << size;
    endfunction

    function automatic logic occ_eq(input int occ, input int val);
        return occ == val;
    endfunction

endpackage

// File: rtl/axi_fifo_sync_flags_if.sv
// axi_fifo_sync_flags_if: one AXI4-Stream link carrying tdata and tlast per beat
interface axi_fifo_sync_flags_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axi_fifo_ram.sv
// axi_fifo_ram: register array with synchronous write and asynchronous read
module axi_fifo_ram
    import axi_fifo_pkg::*;
#(
    parameter int DW = 33,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    // store the accepted beat; contents are never cleared, the pointers define validity
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_fifo_sync_flags.sv
// axi_fifo_sync_flags: single-clock FWFT AXI4-Stream FIFO with registered occupancy/full/empty
module axi_fifo_sync_flags
    import axi_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_fifo_sync_flags_if.slave  s_axis,
    axi_fifo_sync_flags_if.master m_axis,
    output logic [SIZE:0]         occupied,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = depth_of(SIZE);

    logic [SIZE:0]  wr_ptr_q, wr_ptr_d;
    logic [SIZE:0]  rd_ptr_q, rd_ptr_d;
    logic [SIZE:0]  occupied_q, occupied_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           wr_en, rd_en;
    logic [WIDTH:0] rd_word;

    // handshakes, pointer advance and the occupancy/flag values for the next edge
    always_comb begin
        wr_en      = s_axis.tvalid & ~full_q & ~rst;
        rd_en      = ~empty_q & m_axis.tready;
        wr_ptr_d   = wr_ptr_q + {{SIZE{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{SIZE{1'b0}}, rd_en};
        occupied_d = occupied_q + {{SIZE{1'b0}}, wr_en} - {{SIZE{1'b0}}, rd_en};
        full_d     = occ_eq(int'(occupied_d), DEPTH);
        empty_d    = occ_eq(int'(occupied_d), 0);
    end

    // pointer and flag state; reset discards all stored beats
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occupied_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occupied_q <= occupied_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    axi_fifo_ram #(
        .DW (WIDTH + 1),
        .AW (SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[SIZE-1:0]),
        .wdata ({s_axis.tlast, s_axis.tdata}),
        .raddr (rd_ptr_q[SIZE-1:0]),
        .rdata (rd_word)
    );

    // head data is masked while empty so stale storage never reaches the consumer
    always_comb begin
        s_axis.tready = ~full_q & ~rst;
        m_axis.tvalid = ~empty_q;
        m_axis.tdata  = empty_q ? '0 : rd_word[WIDTH-1:0];
        m_axis.tlast  = ~empty_q & rd_word[WIDTH];
        occupied      = occupied_q;
        full          = full_q;
        empty         = empty_q;
    end

endmodule

// File: tb/tb_axi_fifo_sync_flags.sv
// tb_axi_fifo_sync_flags: directed self-checking bench for the stream FIFO
module tb_axi_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] occupied;
    logic       full, empty;
    int         checks = 0;
    int         errors = 0;
    logic [32:0] q[$];

    axi_fifo_sync_flags_if #(.WIDTH(32)) s_if ();
    axi_fifo_sync_flags_if #(.WIDTH(32)) m_if ();

    axi_fifo_sync_flags #(.WIDTH(32), .SIZE(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .occupied (occupied),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r);
        bit wr, rd;
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        m_if.tready = r;
        #1;
        wr = v && !rst && q.size() < 32;
        rd = r && q.size() > 0;
        check("s_tready", s_if.tready, !rst && q.size() < 32);
        check("m_tvalid", m_if.tvalid, q.size() > 0);
        if (q.size() > 0) begin
            check("m_tdata", m_if.tdata, q[0][31:0]);
            check("m_tlast", m_if.tlast, q[0][32]);
        end
        @(posedge clk);
        #1;
        if (rst) q.delete();
        else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back({l, d});
        end
        check("occupied", occupied, q.size());
        check("full", full, q.size() == 32);
        check("empty", empty, q.size() == 0);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_tvalid", m_if.tvalid, 1'b0);
        check("rst_tready", s_if.tready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_tready", s_if.tready, 1'b1);
        check("post_rst_empty", empty, 1'b1);

        for (int i = 1; i <= 32; i++) cycle(1'b1, i, 1'b0, 1'b0);
        check("fill_full", full, 1'b1);
        check("fill_occ", occupied, 32);
        check("fill_tready", s_if.tready, 1'b0);
        cycle(1'b1, 32'd33, 1'b0, 1'b0);
        check("fill_refused_occ", occupied, 32);

        for (int i = 1; i <= 32; i++) begin
            s_if.tvalid = 1'b0;
            m_if.tready = 1'b1;
            #1;
            check("drain_data", m_if.tdata, i);
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        check("drain_empty", empty, 1'b1);
        check("drain_tvalid", m_if.tvalid, 1'b0);
        check("drain_occ", occupied, 0);

        for (int k = 0; k < 70; k++) begin
            cycle(1'b1, 32'd1000 + k, 1'b0, 1'b1);
            check("stream_occ", occupied, 1);
            check("stream_data", m_if.tdata, 32'd1000 + k);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("stream_done_empty", empty, 1'b1);

        for (int b = 1; b <= 32; b++) cycle(1'b1, 32'd200 + b, b == 3 || b == 8, 1'b0);
        check("pkt_full", full, 1'b1);
        cycle(1'b1, 32'd999, 1'b1, 1'b1);
        check("full_rw_occ", occupied, 31);
        for (int b = 2; b <= 32; b++) begin
            s_if.tvalid = 1'b0;
            m_if.tready = 1'b1;
            #1;
            check("pkt_data", m_if.tdata, 32'd200 + b);
            check("pkt_tlast", m_if.tlast, b == 3 || b == 8);
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        check("pkt_empty", empty, 1'b1);

        for (int i = 0; i < 17; i++) cycle(1'b1, 32'd500 + i, 1'b0, 1'b0);
        check("mid_occ", occupied, 17);
        rst = 1'b1;
        cycle(1'b1, 32'd777, 1'b0, 1'b0);
        check("mid_rst_occ", occupied, 0);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_tvalid", m_if.tvalid, 1'b0);
        check("mid_rst_tdata", m_if.tdata, 32'h0);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_post_tready", s_if.tready, 1'b1);
        cycle(1'b1, 32'd42, 1'b1, 1'b0);
        check("mid_post_data", m_if.tdata, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
